fcs_crc32_mb: RTL and testbench
===============================

# fcs_crc32_mb

Multi-byte, frame-aware Ethernet FCS engine that computes IEEE 802.3 CRC-32 over `DATA_BYTES` bytes per beat. Frames are delimited by SOF/EOF, and a partial final beat is handled with a byte-keep mask. The engine produces the transmit FCS and a receive-side residue check in the same pass. It sits on the MAC datapath between the framing logic and the FCS insert/strip stage, and replaces the single-word CRC block for widths from 1 to 16 bytes.

## Interface
- `DATA_BYTES`, 4: bytes per beat. Legal values are 1..16.
- `PIPE`, 0: input register stage. Legal values are 0 or 1. Adds PIPE cycles of latency.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  beat qualifier. The block is always ready and has no backpressure.
- `in_sof`  in  1  first beat of frame.
- `in_eof`  in  1  last beat of frame. May coincide with `in_sof`.
- `in_keep`  in  DATA_BYTES  valid-byte mask. Sampled only on EOF beats. Non-EOF beats are treated as all ones.
- `in_data`  in  8*DATA_BYTES  payload. Lane 0 (`[7:0]`) is first on the wire.
- `out_valid`  out  1  one-cycle result strobe.
- `out_crc`  out  32  FCS to transmit: ~CRC register, reflected. Byte `[7:0]` is sent first.
- `out_ok`  out  1  residue check passed. The frame included a correct FCS.
- `out_err`  out  1  frame closed abnormally: aborted or bad keep.

## Operation
- Algorithm:
  - Reflected CRC-32, polynomial 0xEDB88320, seed 0xFFFFFFFF, LSB-first within each byte.
  - `out_crc` = ~reg.
  - `out_ok` = (reg == 0xDEBB20E3).
- Per beat, lanes are folded in order 0..n-1.
  - On non-EOF beats, n = DATA_BYTES.
  - On EOF beats, n = number of set bits in `in_keep`.
- Legal `in_keep` must be contiguous from lane 0 with n≥1, e.g. 0001, 0011, 0111, 1111.
- FSM states are IDLE and FRAME.
- In IDLE:
  - `in_valid & in_sof`: seed the register, fold the beat, go to FRAME.
  - If `in_eof` is also set, close the frame and stay in IDLE.
  - `in_valid & !in_sof`: discard the beat. No output, state unchanged.
- In FRAME:
  - `in_valid & !in_sof`: fold the beat.
  - `in_valid & in_eof`: close the frame and go to IDLE.
- SOF while in FRAME:
  - Abort the current frame with `out_valid=1`, `out_err=1`, `out_ok=0`, and `out_crc` = ~reg from before this beat.
  - The SOF beat then starts a new frame with a fresh seed.
  - If that new frame also closes on the same beat, its result is held one cycle and issued on the following cycle.
  - Consequently, results are never dropped and are never issued in the same cycle.
- Illegal keep on an EOF beat:
  - Close the frame with `out_err=1` and `out_ok=0`.
  - `out_crc` is undefined but stable.
- Result outputs hold their values until the next `out_valid`.

## Timing
- Reset values:
  - `out_valid=0`, `out_crc=0`, `out_ok=0`, `out_err=0`.
  - FSM in IDLE, CRC register 0xFFFFFFFF, pending-result flag 0.
- Latency: `out_valid` rises 1+PIPE cycles after the EOF beat is sampled.
- Throughput: one beat per cycle, continuously. Back-to-back frames (EOF followed immediately by SOF) lose no cycles.
- `out_valid` is a single-cycle pulse per closed frame.
- Reset asserted mid-frame:
  - Everything returns to reset values immediately.
  - No `out_valid` is produced for the partial frame.
  - The first SOF after reset release is processed normally.
- With PIPE=1, the input register and its valid bit are also cleared by reset.

## Structure
- Package `fcs_pkg` holds:
  - `CRC32_POLY_REFL` = 32'hEDB88320.
  - `CRC32_INIT` = 32'hFFFFFFFF.
  - `CRC32_RESIDUE` = 32'hDEBB20E3.
  - FSM state enum `fcs_state_e` (IDLE, FRAME).
- Sub-module `crc32_byte_step` is combinational: 32-bit reg plus 8-bit byte in, 32-bit reg out.
  - It is chained DATA_BYTES times.
  - The result is tapped after lane n-1 via a mux indexed by the keep count.

## Test plan
- DATA_BYTES=1, ASCII "123456789" as 9 beats (SOF on '1', EOF on '9') -> one `out_valid` 1 cycle later, `out_crc`=0xCBF43926, `out_err`=0.
- DATA_BYTES=4, same string in 3 beats, last beat `in_keep`=0001 -> `out_crc`=0xCBF43926.
  - Repeat with PIPE=1: same result, 2 cycles after EOF.
- DATA_BYTES=4, one SOF+EOF beat with `in_data`=0, keep=1111 -> `out_crc`=0x2144DF1C.
- "123456789" followed by bytes 26 39 F4 CB -> `out_ok`=1. Flip bit 0 of byte '5' -> `out_ok`=0.
- Abort case: SOF, 2 beats, then SOF+EOF "1234" (keep=1111) -> first `out_valid` with `out_err`=1, next cycle `out_valid` with `out_crc`=0x9BE3E0A3 and `out_err`=0.
  - A beat without SOF in IDLE -> no `out_valid`.
- Reset pulse after the second beat of a frame -> no `out_valid`. A following "123456789" frame yields 0xCBF43926.

Source files
------------

// File: rtl/fcs_pkg.sv
// fcs_pkg: CRC-32 constants and FSM encoding shared by the multi-byte FCS engine.
package fcs_pkg;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} fcs_state_e;
endpackage

// File: rtl/crc32_byte_step.sv
// crc32_byte_step: folds one byte, LSB first, into a reflected CRC-32 register.
module crc32_byte_step
    import fcs_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_crc
);
    always_comb begin
        o_crc = i_crc;
        for (int b = 0; b < 8; b++)
            o_crc = (o_crc >> 1) ^ ((o_crc[0] ^ i_byte[b]) ? CRC32_POLY_REFL : 32'h0);
    end
endmodule

// File: rtl/fcs_crc32_mb.sv
// fcs_crc32_mb: frame-aware Ethernet FCS over DATA_BYTES lanes per beat, giving the
// transmit FCS and the receive residue check, with abort results never colliding.
module fcs_crc32_mb
    import fcs_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int PIPE       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic                    in_eof,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic [8*DATA_BYTES-1:0] in_data,
    output logic                    out_valid,
    output logic [31:0]             out_crc,
    output logic                    out_ok,
    output logic                    out_err
);
    localparam int CW = $clog2(DATA_BYTES + 1);

    logic                    w_valid, w_sof, w_eof;
    logic [DATA_BYTES-1:0]   w_keep;
    logic [8*DATA_BYTES-1:0] w_data;

    if (PIPE != 0) begin : g_pipe
        logic                    r_valid, r_sof, r_eof;
        logic [DATA_BYTES-1:0]   r_keep;
        logic [8*DATA_BYTES-1:0] r_data;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
                r_eof   <= 1'b0;
                r_keep  <= '0;
                r_data  <= '0;
            end else begin
                r_valid <= in_valid;
                r_sof   <= in_sof;
                r_eof   <= in_eof;
                r_keep  <= in_keep;
                r_data  <= in_data;
            end
        end
        assign w_valid = r_valid;
        assign w_sof   = r_sof;
        assign w_eof   = r_eof;
        assign w_keep  = r_keep;
        assign w_data  = r_data;
    end else begin : g_direct
        assign w_valid = in_valid;
        assign w_sof   = in_sof;
        assign w_eof   = in_eof;
        assign w_keep  = in_keep;
        assign w_data  = in_data;
    end

    fcs_state_e  r_state, w_state_nx;
    logic [31:0] r_crc;
    logic        r_pend, r_pend_ok, r_pend_err;
    logic [31:0] r_pend_crc;
    logic        r_out_valid, r_out_ok, r_out_err;
    logic [31:0] r_out_crc;

    logic [31:0]   w_chain [DATA_BYTES+1];
    logic [31:0]   w_tap;
    logic [CW-1:0] w_cnt, w_n;
    logic          w_keep_ok, w_good;
    logic          w_accept, w_abort, w_close;
    logic          w_res_ok, w_res_err;
    logic          w_emit, w_emit_ok, w_emit_err, w_pend_nx;
    logic [31:0]   w_emit_crc;

    // Lane chain: a fresh seed on SOF, otherwise continue from the running register.
    assign w_chain[0] = w_sof ? CRC32_INIT : r_crc;
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        crc32_byte_step u_step (
            .i_crc  (w_chain[i]),
            .i_byte (w_data[8*i +: 8]),
            .o_crc  (w_chain[i+1])
        );
    end

    always_comb begin
        w_cnt     = '0;
        w_keep_ok = w_keep[0];
        for (int k = 0; k < DATA_BYTES; k++) w_cnt = w_cnt + CW'(w_keep[k]);
        for (int k = 1; k < DATA_BYTES; k++) w_keep_ok = w_keep_ok & (w_keep[k-1] | !w_keep[k]);
    end

    assign w_n       = w_eof ? w_cnt : CW'(DATA_BYTES);
    assign w_tap     = w_chain[w_n];
    assign w_good    = !w_eof | w_keep_ok;
    assign w_res_ok  = w_good & (w_tap == CRC32_RESIDUE);
    assign w_res_err = !w_good;

    assign w_accept = w_valid & (w_sof | (r_state == FRAME));
    assign w_abort  = w_valid & w_sof & (r_state == FRAME);
    assign w_close  = w_accept & w_eof;

    // Result slot priority: held result, then abort, then a normal close.
    always_comb begin
        w_state_nx = r_state;
        if (w_accept) w_state_nx = w_eof ? IDLE : FRAME;
        w_emit     = r_pend | w_abort | w_close;
        w_emit_crc = r_pend ? r_pend_crc : w_abort ? ~r_crc : ~w_tap;
        w_emit_ok  = r_pend ? r_pend_ok  : !w_abort & w_res_ok;
        w_emit_err = r_pend ? r_pend_err : w_abort | w_res_err;
        w_pend_nx  = w_close & (r_pend | w_abort);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc       <= CRC32_INIT;
            r_pend      <= 1'b0;
            r_pend_crc  <= '0;
            r_pend_ok   <= 1'b0;
            r_pend_err  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_crc   <= '0;
            r_out_ok    <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            if (w_accept) r_crc <= w_tap;
            r_pend <= w_pend_nx;
            if (w_pend_nx) begin
                r_pend_crc <= ~w_tap;
                r_pend_ok  <= w_res_ok;
                r_pend_err <= w_res_err;
            end
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_crc <= w_emit_crc;
                r_out_ok  <= w_emit_ok;
                r_out_err <= w_emit_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_crc   = r_out_crc;
    assign out_ok    = r_out_ok;
    assign out_err   = r_out_err;
endmodule

// File: tb/tb_fcs_crc32_mb.sv
// tb_fcs_crc32_mb: scoreboard bench driving a PIPE=0 and a PIPE=1 engine with the same beats.
module tb_fcs_crc32_mb;
    localparam int DB = 4;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          cyc;
        logic [31:0] crc;
        logic        ok;
        logic        err;
        logic        dc;
    } exp_t;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic [DB-1:0] in_keep = '0;
    logic [8*DB-1:0] in_data = '0;
    logic          a_v, a_ok, a_err, b_v, b_ok, b_err;
    logic [31:0]   a_crc, b_crc;
    int            cyc = 0, checks = 0, errors = 0, last_out = -100;
    exp_t          qa[$], qb[$];
    bit            in_frame = 1'b0;
    bq_t           fq;

    fcs_crc32_mb #(.DATA_BYTES(DB), .PIPE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_keep(in_keep), .in_data(in_data),
        .out_valid(a_v), .out_crc(a_crc), .out_ok(a_ok), .out_err(a_err));

    fcs_crc32_mb #(.DATA_BYTES(DB), .PIPE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_keep(in_keep), .in_data(in_data),
        .out_valid(b_v), .out_crc(b_crc), .out_ok(b_ok), .out_err(b_err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the standard reflected CRC-32 of a byte list, already complemented (the FCS).
    function automatic logic [31:0] crc32(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input bq_t b);
        int n;
        n = b.size();
        if (n < 4) return 1'b0;
        return crc32(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
    endfunction

    function automatic bit keep_legal(input logic [DB-1:0] k);
        for (int n = 1; n <= DB; n++) if (int'(k) == (1 << n) - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Results are issued in order, one per cycle at most, no earlier than 1 cycle after the beat.
    task automatic push(input logic [31:0] crc, input logic ok, input logic err, input logic dc);
        int c;
        c = (cyc + 1 > last_out + 1) ? cyc + 1 : last_out + 1;
        qa.push_back('{c, crc, ok, err, dc});
        qb.push_back('{c + 1, crc, ok, err, dc});
        last_out = c;
    endtask

    task automatic model(input logic sof, input logic eof, input logic [DB-1:0] keep,
                         input logic [8*DB-1:0] data);
        int n;
        bit good;
        if (sof) begin
            if (in_frame) push(crc32(fq, fq.size()), 1'b0, 1'b1, 1'b0);
            fq.delete();
            in_frame = 1'b1;
        end else if (!in_frame) return;
        n = eof ? $countones(keep) : DB;
        good = !eof || keep_legal(keep);
        for (int l = 0; l < n; l++) fq.push_back(data[8*l +: 8]);
        if (eof) begin
            push(crc32(fq, fq.size()), good && fcs_ok(fq), !good, !good);
            in_frame = 1'b0;
        end
    endtask

    task automatic beat(input logic v, input logic sof, input logic eof,
                        input logic [DB-1:0] keep, input logic [8*DB-1:0] data);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_eof   = eof;
        in_keep  = keep;
        in_data  = data;
        if (v) model(sof, eof, keep, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            beat(1'b0, 1'($urandom), 1'($urandom), DB'($urandom), (8*DB)'($urandom));
    endtask

    task automatic send(input bq_t q, input bit close, input bit badk, input bit gap);
        int n, m;
        bit last;
        logic [DB-1:0] keep;
        logic [8*DB-1:0] d;
        n = q.size();
        for (int i = 0; i < n; i += DB) begin
            last = (i + DB >= n);
            m = last ? n - i : DB;
            if (last && !close) break;
            keep = DB'((1 << m) - 1);
            d = (8*DB)'($urandom);
            for (int l = 0; l < m; l++) d[8*l +: 8] = q[i + l];
            if (last && badk) begin
                keep = DB'($urandom);
                while (keep_legal(keep)) keep = DB'($urandom);
            end
            if (gap && i > 0 && $urandom_range(0, 3) == 0) idle(1);
            beat(1'b1, i == 0, last, keep, d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_frame = 1'b0;
        fq.delete();
        @(negedge clk);
        chk("rst a valid", 32'(a_v), 0);
        chk("rst a crc", a_crc, 0);
        chk("rst a ok", 32'(a_ok), 0);
        chk("rst a err", 32'(a_err), 0);
        chk("rst b valid", 32'(b_v), 0);
        chk("rst b crc", b_crc, 0);
        chk("rst b ok", 32'(b_ok), 0);
        chk("rst b err", 32'(b_err), 0);
        rst_n = 1'b1;
    endtask

    task automatic mon(input int id, input logic v, input logic [31:0] crc,
                       input logic ok, input logic err);
        exp_t e;
        bit have, due;
        have = (id == 0) ? (qa.size() != 0) : (qb.size() != 0);
        if (have) begin
            if (id == 0) e = qa[0];
            else         e = qb[0];
        end
        due = have && e.cyc == cyc;
        checks++;
        if (v !== due) begin
            errors++;
            $display("FAIL out_valid dut%0d cyc %0d: got %b expected %b", id, cyc, v, due);
        end
        if (have && e.cyc <= cyc) begin
            if (id == 0) void'(qa.pop_front());
            else         void'(qb.pop_front());
            if (due && v) begin
                if (!e.dc) chk($sformatf("crc dut%0d cyc %0d", id, cyc), crc, e.crc);
                chk($sformatf("ok dut%0d cyc %0d", id, cyc), 32'(ok), 32'(e.ok));
                chk($sformatf("err dut%0d cyc %0d", id, cyc), 32'(err), 32'(e.err));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_v, a_crc, a_ok, a_err);
        mon(1, b_v, b_crc, b_ok, b_err);
    end

    initial begin
        bq_t q;
        int len, mode;
        logic [31:0] c;
        #1 rst_n = 1'b0;
        do_reset();

        send(s2q("123456789"), 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("kat a crc", a_crc, 32'hCBF43926);
        chk("kat b crc", b_crc, 32'hCBF43926);
        chk("kat a err", 32'(a_err), 0);

        beat(1'b1, 1'b1, 1'b1, 4'hF, 32'h0);
        idle(3);
        chk("zero a crc", a_crc, 32'h2144DF1C);
        chk("zero b crc", b_crc, 32'h2144DF1C);

        q = s2q("123456789");
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send(q, 1'b1, 1'b0, 1'b1);
        idle(3);
        chk("residue a ok", 32'(a_ok), 1);
        chk("residue b ok", 32'(b_ok), 1);
        q[4] = q[4] ^ 8'h01;
        send(q, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("residue bad a ok", 32'(a_ok), 0);
        chk("residue bad b ok", 32'(b_ok), 0);

        beat(1'b1, 1'b1, 1'b0, 4'hF, 32'($urandom));
        beat(1'b1, 1'b0, 1'b0, 4'hF, 32'($urandom));
        beat(1'b1, 1'b1, 1'b1, 4'hF, 32'h34333231);
        idle(3);
        chk("abort new a crc", a_crc, 32'h9BE3E0A3);
        chk("abort new a err", 32'(a_err), 0);
        chk("abort new b crc", b_crc, 32'h9BE3E0A3);

        beat(1'b1, 1'b0, 1'b0, 4'hF, 32'($urandom));
        beat(1'b1, 1'b0, 1'b1, 4'hF, 32'($urandom));
        idle(3);

        beat(1'b1, 1'b1, 1'b1, 4'b0101, 32'($urandom));
        idle(3);
        chk("badkeep a err", 32'(a_err), 1);
        chk("badkeep a ok", 32'(a_ok), 0);
        beat(1'b1, 1'b1, 1'b1, 4'b0000, 32'($urandom));
        idle(3);
        chk("nokeep b err", 32'(b_err), 1);

        beat(1'b1, 1'b1, 1'b0, 4'hF, 32'($urandom));
        beat(1'b1, 1'b0, 1'b0, 4'hF, 32'($urandom));
        do_reset();
        idle(2);
        send(s2q("123456789"), 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("post-reset a crc", a_crc, 32'hCBF43926);
        chk("post-reset b crc", b_crc, 32'hCBF43926);

        for (int f = 0; f < 300; f++) begin
            len = $urandom_range(1, 24);
            mode = $urandom_range(0, 9);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                c = crc32(q, q.size());
                q.push_back(c[7:0]); q.push_back(c[15:8]); q.push_back(c[23:16]); q.push_back(c[31:24]);
            end
            if ($urandom_range(0, 7) == 0)
                beat(1'b1, 1'b0, 1'($urandom), DB'($urandom), (8*DB)'($urandom));
            send(q, mode != 0, mode == 1, 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(6);
        chk("queue a drained", qa.size(), 0);
        chk("queue b drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
